// File: rtl/sdram_device_model.sv
// Synthesizable SDR SDRAM responder: command decode, init sequencing, per-bank rows, burst engine, RAM.
// Define SDRAM_MODEL_CHECK_EN to enable tRCD/tRP checks and the err_flag/err_count violation reporting.
module sdram_device_model #(
  parameter int ROW_W    = 4,
  parameter int COL_W    = 8,
  parameter int TRCD_CYC = 2,
  parameter int TRP_CYC  = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic [12:0] sdram_a,
  input  logic [1:0]  sdram_ba,
  input  logic [1:0]  sdram_dm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic [1:0]  mode_cl,
  output logic [3:0]  mode_bl,
  output logic [15:0] refresh_cnt,
  output logic        err_flag,
  output logic [7:0]  err_count
);
  localparam int AW = 2 + ROW_W + COL_W;

  typedef enum logic [2:0] {WAIT_PRE, WAIT_REF1, WAIT_REF2, WAIT_MRS, READY} init_e;
  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} burst_e;

  logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_mrs, cmd_bst;

  init_e             init_q;
  logic              init_done_q;
  logic              init_ready;
  logic [1:0]        mode_cl_q, mode_cl_d;
  logic [3:0]        mode_bl_q, mode_bl_d;
  logic [15:0]       ref_cnt_q, ref_cnt_d;
  logic [3:0]        open_q, open_d;
  logic [ROW_W-1:0]  row_q [4];
  logic [ROW_W-1:0]  row_d [4];
  burst_e            burst_q, burst_d;
  logic [1:0]        bbank_q, bbank_d;
  logic [ROW_W-1:0]  brow_q, brow_d;
  logic [COL_W-1:0]  bcol_q, bcol_d;
  logic [2:0]        bidx_q, bidx_d;
  logic [3:0]        blen_q, blen_d;
  logic              bap_q, bap_d;
  logic              p0_vld_q, p1_vld_q;
  logic [15:0]       p0_dat_q, p1_dat_q;
  logic              dq_oe_q, dq_oe_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic [15:0]       mem_q [0:(1<<AW)-1];

  logic              viol, rw_ok, term, burst_last;
  logic              mem_we, rd_en;
  logic [AW-1:0]     mem_waddr, rd_addr, cur_addr;
  logic [ROW_W-1:0]  a_row;
  logic [COL_W-1:0]  a_col;
  logic              a_unused;

  function automatic logic [COL_W-1:0] burst_col(input logic [COL_W-1:0] base,
                                                 input logic [2:0] idx, input logic [3:0] bl);
    logic [COL_W-1:0] mask;
    mask = COL_W'(bl - 4'd1);
    return (base & ~mask) | ((base + COL_W'(idx)) & mask);
  endfunction

  always_comb begin
    cmd_act = 1'b0; cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_pre = 1'b0;
    cmd_ref = 1'b0; cmd_mrs = 1'b0; cmd_bst = 1'b0;
    if (!sdram_cs_n) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  cmd_act = 1'b1;
        3'b101:  cmd_rd  = 1'b1;
        3'b100:  cmd_wr  = 1'b1;
        3'b010:  cmd_pre = 1'b1;
        3'b001:  cmd_ref = 1'b1;
        3'b000:  cmd_mrs = 1'b1;
        3'b110:  cmd_bst = 1'b1;
        default: ;
      endcase
    end
  end

  assign a_row      = sdram_a[ROW_W-1:0];
  assign a_col      = sdram_a[COL_W-1:0];
  assign a_unused   = ^sdram_a;
  assign init_ready = (init_q == READY);
  assign rw_ok      = init_ready && open_q[sdram_ba] && (cmd_rd || cmd_wr);
  assign term       = rw_ok || cmd_bst || (cmd_pre && (sdram_a[10] || sdram_ba == bbank_q));
  assign cur_addr   = {bbank_q, brow_q, burst_col(bcol_q, bidx_q, blen_q)};
  assign burst_last = (bidx_q == 3'(blen_q - 4'd1));

`ifdef SDRAM_MODEL_CHECK_EN
  localparam logic [3:0] TRCD_LD = 4'(TRCD_CYC - 1);
  localparam logic [3:0] TRP_LD  = 4'(TRP_CYC - 1);
  logic [3:0] trcd_q [4];
  logic [3:0] trcd_d [4];
  logic [3:0] trp_q [4];
  logic [3:0] trp_d [4];
`endif

  always_comb begin
    open_d    = open_q;
    row_d     = row_q;
    burst_d   = burst_q;
    bbank_d   = bbank_q;
    brow_d    = brow_q;
    bcol_d    = bcol_q;
    bidx_d    = bidx_q;
    blen_d    = blen_q;
    bap_d     = bap_q;
    mode_cl_d = mode_cl_q;
    mode_bl_d = mode_bl_q;
    ref_cnt_d = ref_cnt_q;
    viol      = 1'b0;
    mem_we    = 1'b0;
    rd_en     = 1'b0;
    mem_waddr = '0;
    rd_addr   = '0;
`ifdef SDRAM_MODEL_CHECK_EN
    for (int b = 0; b < 4; b++) begin
      trcd_d[b] = (trcd_q[b] != 4'd0) ? trcd_q[b] - 4'd1 : 4'd0;
      trp_d[b]  = (trp_q[b]  != 4'd0) ? trp_q[b]  - 4'd1 : 4'd0;
    end
`endif
    // A READ interrupting a write burst still lets this edge's write word land.
    if ((burst_q == B_WRITE && (!term || (rw_ok && cmd_rd))) || (burst_q == B_READ && !term)) begin
      if (burst_q == B_WRITE) begin
        mem_we    = 1'b1;
        mem_waddr = cur_addr;
      end else begin
        rd_en   = 1'b1;
        rd_addr = cur_addr;
      end
      if (burst_last) begin
        burst_d = B_IDLE;
        if (bap_q) begin
          open_d[bbank_q] = 1'b0;
`ifdef SDRAM_MODEL_CHECK_EN
          trp_d[bbank_q] = TRP_LD;
`endif
        end
      end else begin
        bidx_d = bidx_q + 3'd1;
      end
    end else if (term) begin
      burst_d = B_IDLE;
    end

    if (cmd_act) begin
      if (!init_ready) begin
        viol = 1'b1;
      end else if (!(open_q[sdram_ba] && row_q[sdram_ba] == a_row)) begin
        if (open_q[sdram_ba]) viol = 1'b1;
`ifdef SDRAM_MODEL_CHECK_EN
        if (trp_q[sdram_ba] != 4'd0) viol = 1'b1;
        trcd_d[sdram_ba] = TRCD_LD;
`endif
        open_d[sdram_ba] = 1'b1;
        row_d[sdram_ba]  = a_row;
      end
    end

    if (cmd_rd || cmd_wr) begin
      if (!rw_ok) begin
        viol = 1'b1;
      end else begin
`ifdef SDRAM_MODEL_CHECK_EN
        if (trcd_q[sdram_ba] != 4'd0) viol = 1'b1;
`endif
        bbank_d = sdram_ba;
        brow_d  = row_q[sdram_ba];
        bcol_d  = a_col;
        blen_d  = mode_bl_q;
        bap_d   = sdram_a[10];
        bidx_d  = 3'd1;
        if (cmd_wr) begin
          mem_we    = 1'b1;
          mem_waddr = {sdram_ba, row_q[sdram_ba], a_col};
        end else begin
          rd_en   = 1'b1;
          rd_addr = {sdram_ba, row_q[sdram_ba], a_col};
        end
        if (mode_bl_q == 4'd1) begin
          burst_d = B_IDLE;
          if (sdram_a[10]) begin
            open_d[sdram_ba] = 1'b0;
`ifdef SDRAM_MODEL_CHECK_EN
            trp_d[sdram_ba] = TRP_LD;
`endif
          end
        end else begin
          burst_d = cmd_rd ? B_READ : B_WRITE;
        end
      end
    end

    if (cmd_pre) begin
      for (int b = 0; b < 4; b++) begin
        if (sdram_a[10] || sdram_ba == 2'(b)) begin
          open_d[b] = 1'b0;
`ifdef SDRAM_MODEL_CHECK_EN
          if (open_q[b]) trp_d[b] = TRP_LD;
`endif
        end
      end
    end

    if (cmd_ref) begin
      ref_cnt_d = ref_cnt_q + 16'd1;
      if (|open_q) viol = 1'b1;
    end

    if (cmd_mrs) begin
      if (sdram_a[6:4] == 3'd2 || sdram_a[6:4] == 3'd3) mode_cl_d = sdram_a[5:4];
      else viol = 1'b1;
      if (!sdram_a[2]) mode_bl_d = 4'd1 << sdram_a[1:0];
      else viol = 1'b1;
    end
  end

  // CL2 drives from the RAM output register, CL3 adds one more stage.
  always_comb begin
    dq_oe_d  = (mode_cl_q == 2'd3) ? p1_vld_q : p0_vld_q;
    dq_out_d = '0;
    if (dq_oe_d) dq_out_d = (mode_cl_q == 2'd3) ? p1_dat_q : p0_dat_q;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      init_q      <= WAIT_PRE;
      init_done_q <= 1'b0;
    end else if (sdram_cke) begin
      case (init_q)
        WAIT_PRE:  if (cmd_pre && sdram_a[10]) init_q <= WAIT_REF1;
        WAIT_REF1: if (cmd_ref) init_q <= WAIT_REF2;
        WAIT_REF2: if (cmd_ref) init_q <= WAIT_MRS;
        WAIT_MRS:  if (cmd_mrs) begin
                     init_q      <= READY;
                     init_done_q <= 1'b1;
                   end
        READY:     init_done_q <= 1'b1;
        default:   init_q <= WAIT_PRE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mode_cl_q <= 2'd2;
      mode_bl_q <= 4'd1;
      ref_cnt_q <= '0;
      open_q    <= '0;
      for (int b = 0; b < 4; b++) row_q[b] <= '0;
      burst_q   <= B_IDLE;
      bbank_q   <= '0;
      brow_q    <= '0;
      bcol_q    <= '0;
      bidx_q    <= '0;
      blen_q    <= 4'd1;
      bap_q     <= 1'b0;
      p0_vld_q  <= 1'b0;
      p1_vld_q  <= 1'b0;
      p1_dat_q  <= '0;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
    end else if (sdram_cke) begin
      mode_cl_q <= mode_cl_d;
      mode_bl_q <= mode_bl_d;
      ref_cnt_q <= ref_cnt_d;
      open_q    <= open_d;
      row_q     <= row_d;
      burst_q   <= burst_d;
      bbank_q   <= bbank_d;
      brow_q    <= brow_d;
      bcol_q    <= bcol_d;
      bidx_q    <= bidx_d;
      blen_q    <= blen_d;
      bap_q     <= bap_d;
      p0_vld_q  <= rd_en;
      p1_vld_q  <= p0_vld_q;
      p1_dat_q  <= p0_dat_q;
      dq_oe_q   <= dq_oe_d;
      dq_out_q  <= dq_out_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst && sdram_cke) begin
      if (mem_we && !sdram_dm[0]) mem_q[mem_waddr][7:0]  <= dq_in[7:0];
      if (mem_we && !sdram_dm[1]) mem_q[mem_waddr][15:8] <= dq_in[15:8];
      if (rd_en) p0_dat_q <= mem_q[rd_addr];
    end
  end

`ifdef SDRAM_MODEL_CHECK_EN
  logic       err_flag_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      for (int b = 0; b < 4; b++) begin
        trcd_q[b] <= '0;
        trp_q[b]  <= '0;
      end
    end else if (sdram_cke) begin
      trcd_q <= trcd_d;
      trp_q  <= trp_d;
      if (viol) begin
        err_flag_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_cnt_q;
`else
  logic [1:0] chk_unused;
  assign chk_unused = {viol, (TRCD_CYC + TRP_CYC) > 0};
  assign err_flag   = 1'b0;
  assign err_count  = '0;
`endif

  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign init_done   = init_done_q;
  assign mode_cl     = mode_cl_q;
  assign mode_bl     = mode_bl_q;
  assign refresh_cnt = ref_cnt_q;
endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: init, CL2/CL3 reads, burst wrap, byte masks, violations, reset.
module tb_sdram_device_model;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
`ifdef SDRAM_MODEL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk_sys, rst, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba, sdram_dm;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, init_done, err_flag;
  logic [1:0]  mode_cl;
  logic [3:0]  mode_bl;
  logic [15:0] refresh_cnt;
  logic [7:0]  err_count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_wrap [4] = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};

  sdram_device_model dut (
    .clk_sys(clk_sys), .rst(rst), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_a(sdram_a), .sdram_ba(sdram_ba), .sdram_dm(sdram_dm),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .init_done(init_done),
    .mode_cl(mode_cl), .mode_bl(mode_bl), .refresh_cnt(refresh_cnt),
    .err_flag(err_flag), .err_count(err_count)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command at the negedge, let the DUT sample it, return at the following negedge.
  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] d, input logic [1:0] dm);
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba = ba;
    sdram_a  = a;
    dq_in    = d;
    sdram_dm = dm;
    @(posedge clk_sys);
    @(negedge clk_sys);
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
  endtask

  task automatic nop();
    issue(C_NOP, 2'd0, 13'd0, 16'd0, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    sdram_cke = 1'b1;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    sdram_a = '0; sdram_ba = '0; sdram_dm = '0; dq_in = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    chk("rst_oe",   32'(dq_oe), 0);
    chk("rst_dq",   32'(dq_out), 0);
    chk("rst_init", 32'(init_done), 0);
    chk("rst_cl",   32'(mode_cl), 2);
    chk("rst_bl",   32'(mode_bl), 1);
    chk("rst_ref",  32'(refresh_cnt), 0);
    chk("rst_errf", 32'(err_flag), 0);
    chk("rst_errc", 32'(err_count), 0);

    issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'd0);
    issue(C_REF, 2'd0, 13'h000, 16'd0, 2'd0);
    nop();
    issue(C_REF, 2'd0, 13'h000, 16'd0, 2'd0);
    chk("init_before_mrs", 32'(init_done), 0);
    issue(C_MRS, 2'd0, 13'h020, 16'd0, 2'd0);
    chk("init_done", 32'(init_done), 1);
    chk("init_cl",   32'(mode_cl), 2);
    chk("init_bl",   32'(mode_bl), 1);
    chk("init_ref",  32'(refresh_cnt), 2);

    issue(C_ACT, 2'd1, 13'h003, 16'd0, 2'd0);
    nop();
    issue(C_WR, 2'd1, 13'h012, 16'hBEEF, 2'd0);
    issue(C_RD, 2'd1, 13'h012, 16'd0, 2'd0);
    chk("cl2_early", 32'(dq_oe), 0);
    nop();
    chk("cl2_oe",   32'(dq_oe), 1);
    chk("cl2_data", 32'(dq_out), 'hBEEF);
    nop();
    chk("cl2_end",  32'(dq_oe), 0);

    sdram_cke = 1'b0;
    issue(C_REF, 2'd0, 13'h000, 16'd0, 2'd0);
    sdram_cke = 1'b1;
    chk("cke_ref", 32'(refresh_cnt), 2);
    chk("cke_err", 32'(err_count), 0);

    issue(C_MRS, 2'd0, 13'h032, 16'd0, 2'd0);
    chk("mrs_cl3", 32'(mode_cl), 3);
    chk("mrs_bl4", 32'(mode_bl), 4);
    issue(C_WR,  2'd1, 13'h004, 16'h1111, 2'd0);
    issue(C_NOP, 2'd0, 13'h000, 16'h2222, 2'd0);
    issue(C_NOP, 2'd0, 13'h000, 16'h3333, 2'd0);
    issue(C_NOP, 2'd0, 13'h000, 16'h4444, 2'd0);
    issue(C_RD,  2'd1, 13'h006, 16'd0, 2'd0);
    nop();
    chk("cl3_early", 32'(dq_oe), 0);
    for (int i = 0; i < 4; i++) begin
      nop();
      chk("cl3_oe",   32'(dq_oe), 1);
      chk("cl3_wrap", 32'(dq_out), 32'(exp_wrap[i]));
    end
    nop();
    chk("cl3_end", 32'(dq_oe), 0);

    issue(C_MRS, 2'd0, 13'h020, 16'd0, 2'd0);
    issue(C_WR, 2'd1, 13'h020, 16'hA5A5, 2'b00);
    issue(C_WR, 2'd1, 13'h020, 16'h5A5A, 2'b10);
    issue(C_RD, 2'd1, 13'h020, 16'd0, 2'b00);
    nop();
    chk("dm_data", 32'(dq_out), 'hA55A);
    nop();

    issue(C_ACT, 2'd2, 13'h005, 16'd0, 2'd0);
    issue(C_RD,  2'd2, 13'h000, 16'd0, 2'd0);
    issue(C_RD,  2'd3, 13'h000, 16'd0, 2'd0);
    nop();
    chk("closed_rd_oe", 32'(dq_oe), 0);
    issue(C_REF, 2'd0, 13'h000, 16'd0, 2'd0);
    chk("viol_cnt3", 32'(err_count), 3 * CHK);
    chk("viol_flag", 32'(err_flag), CHK);
    chk("ref_open",  32'(refresh_cnt), 3);

    issue(C_MRS, 2'd0, 13'h052, 16'd0, 2'd0);
    chk("bad_cl_kept", 32'(mode_cl), 2);
    chk("bl_updated",  32'(mode_bl), 4);
    chk("viol_cnt4",   32'(err_count), 4 * CHK);

    issue(C_MRS, 2'd0, 13'h020, 16'd0, 2'd0);
    issue(C_RD,  2'd1, 13'h412, 16'd0, 2'd0);
    issue(C_RD,  2'd1, 13'h012, 16'd0, 2'd0);
    chk("ap_oe",   32'(dq_oe), 1);
    chk("ap_data", 32'(dq_out), 'hBEEF);
    nop();
    chk("ap_closed", 32'(dq_oe), 0);
    chk("viol_cnt5", 32'(err_count), 5 * CHK);

    issue(C_MRS, 2'd0, 13'h023, 16'd0, 2'd0);
    chk("mrs_bl8", 32'(mode_bl), 8);
    issue(C_RD, 2'd2, 13'h000, 16'd0, 2'd0);
    nop();
    chk("bl8_oe", 32'(dq_oe), 1);
    rst = 1'b1;
    nop();
    rst = 1'b0;
    chk("midrst_oe",   32'(dq_oe), 0);
    chk("midrst_init", 32'(init_done), 0);
    chk("midrst_bl",   32'(mode_bl), 1);
    chk("midrst_err",  32'(err_count), 0);
    issue(C_RD, 2'd2, 13'h000, 16'd0, 2'd0);
    nop();
    chk("preinit_rd_oe1", 32'(dq_oe), 0);
    nop();
    chk("preinit_rd_oe2", 32'(dq_oe), 0);
    chk("preinit_viol",   32'(err_count), CHK);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
